// File: rtl/gray_conv_pkg.sv
// -----------------------------------------------------------------------------
// gray_conv_pkg
// Shared constants and conversion helpers for the pipelined Binary<->Gray
// converter.
//
// Contents:
//   MODE_BIN2GRAY / MODE_GRAY2BIN : values carried on the per-word mode tag
//   gray_word_t                   : widest word the helpers operate on
//   bin2gray(w), gray2bin(w)      : conversions on a zero-extended word
//
// Width handling:
//   Callers zero-extend a DATA_WIDTH word to gray_word_t and truncate the
//   result back to DATA_WIDTH. Both conversions only propagate information
//   from high bits to low bits, so zero padding above DATA_WIDTH leaves the
//   low DATA_WIDTH bits exactly equal to a native DATA_WIDTH conversion.
// -----------------------------------------------------------------------------
package gray_conv_pkg;

    localparam int GRAY_MAX_WIDTH = 64;

    localparam logic MODE_BIN2GRAY = 1'b0;
    localparam logic MODE_GRAY2BIN = 1'b1;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    // G = B ^ (B >> 1)
    function automatic gray_word_t bin2gray(input gray_word_t w);
        return w ^ (w >> 1);
    endfunction

    // B[MSB] = G[MSB]; B[i] = B[i+1] ^ G[i], walking from the MSB down.
    function automatic gray_word_t gray2bin(input gray_word_t w);
        gray_word_t b;
        b = '0;
        b[GRAY_MAX_WIDTH-1] = w[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ w[i];
        end
        return b;
    endfunction

endpackage : gray_conv_pkg

// File: rtl/binary_gray_converter_pipelined_gray_step_checker.sv
// -----------------------------------------------------------------------------
// gray_step_checker
// Watches accepted Gray->binary input words and flags any word that differs
// from the previous accepted Gray->binary word in more than one bit.
// Only instantiated when GRAY_STEP_CHECK_EN is defined.
//
// Ports:
//   clk_sys    : clock, rising edge
//   rst        : asynchronous active-high reset
//   accept_in  : a word is accepted into the pipeline this cycle
//   mode_in    : mode tag of the word being accepted
//   data_in    : word being accepted
//   err_out    : combinational step error for the word being accepted
// -----------------------------------------------------------------------------
module gray_step_checker
    import gray_conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  accept_in,
    input  logic                  mode_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  err_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] prev_d;
    logic                  prev_valid_q;
    logic                  prev_valid_d;

    logic [DATA_WIDTH-1:0] diff;
    logic [CNT_W-1:0]      ones;
    logic                  multi_bit;

    always_comb begin
        diff = data_in ^ prev_q;
        ones = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ones = ones + CNT_W'(diff[i]);
        end
        // Distance 0 (repeated word) is a legal step.
        multi_bit = (ones > CNT_W'(1));
    end

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        err_out      = 1'b0;
        if (accept_in) begin
            if (mode_in == MODE_GRAY2BIN) begin
                err_out      = prev_valid_q & multi_bit;
                prev_d       = data_in;
                prev_valid_d = 1'b1;
            end else begin
                // A binary->Gray word breaks the Gray sequence.
                prev_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule : gray_step_checker

// File: rtl/binary_gray_converter_pipelined.sv
// -----------------------------------------------------------------------------
// binary_gray_converter_pipelined
// Two-stage, width-generic, bidirectional Binary<->Gray converter with a
// valid/ready handshake on both sides and a global stall enable.
//
// Stage 1 captures {data, mode, valid}; the conversion sits between stage 1
// and stage 2; stage 2 drives the outputs. An accepted word appears on the
// outputs one edge after the edge that accepted it.
//
// Parameters:
//   DATA_WIDTH : word width, 2..GRAY_MAX_WIDTH
//
// Ports:
//   Clock_In            : clock, rising edge
//   Reset_In            : asynchronous active-high reset, flushes both stages
//   Enable_In           : low stalls every register and forces Ready_Out low
//   Mode_In             : 0 = binary->Gray, 1 = Gray->binary (per word)
//   Data_In, Valid_In   : upstream word and its valid
//   Ready_Out           : block accepts a word this cycle
//   Data_Out, Mode_Out  : converted word and the mode tag that produced it
//   Valid_Out, Ready_In : downstream handshake
//   Gray_Step_Error_Out : present only with GRAY_STEP_CHECK_EN; flags a
//                         Gray->binary word more than one bit away from the
//                         previous accepted Gray->binary word
//
// Build option: define GRAY_STEP_CHECK_EN to add the Gray step checker and
// the Gray_Step_Error_Out port.
// -----------------------------------------------------------------------------
module binary_gray_converter_pipelined
    import gray_conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Mode_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Mode_Out,
    output logic                  Valid_Out,
    input  logic                  Ready_In
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic                  Gray_Step_Error_Out
`endif
);

    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [DATA_WIDTH-1:0] s1_data_d;
    logic                  s1_mode_q;
    logic                  s1_mode_d;
    logic                  s1_valid_q;
    logic                  s1_valid_d;

    logic [DATA_WIDTH-1:0] s2_data_q;
    logic [DATA_WIDTH-1:0] s2_data_d;
    logic                  s2_mode_q;
    logic                  s2_mode_d;
    logic                  s2_valid_q;
    logic                  s2_valid_d;

    logic                  adv1;
    logic                  adv2;
    logic [DATA_WIDTH-1:0] conv_data;

    // Stage 2 frees up when empty or when downstream takes its word; stage 1
    // can load when empty or when stage 2 takes its word. Loading a bubble
    // into a stage is what collapses bubbles.
    always_comb begin
        adv2 = Enable_In & (~s2_valid_q | Ready_In);
        adv1 = Enable_In & (~s1_valid_q | adv2);
    end

    always_comb begin
        if (s1_mode_q == MODE_GRAY2BIN) begin
            conv_data = DATA_WIDTH'(gray2bin(gray_word_t'(s1_data_q)));
        end else begin
            conv_data = DATA_WIDTH'(bin2gray(gray_word_t'(s1_data_q)));
        end
    end

    always_comb begin
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_mode_d  = s2_mode_q;
        s2_valid_d = s2_valid_q;
        if (adv1) begin
            s1_data_d  = Data_In;
            s1_mode_d  = Mode_In;
            s1_valid_d = Valid_In;
        end
        if (adv2) begin
            s2_data_d  = conv_data;
            s2_mode_d  = s1_mode_q;
            s2_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            s1_data_q  <= '0;
            s1_mode_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_valid_q <= s1_valid_d;
            s2_data_q  <= s2_data_d;
            s2_mode_q  <= s2_mode_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign Ready_Out = adv1;
    assign Data_Out  = s2_data_q;
    assign Mode_Out  = s2_mode_q;
    assign Valid_Out = s2_valid_q;

`ifdef GRAY_STEP_CHECK_EN
    logic s1_err_q;
    logic s1_err_d;
    logic s2_err_q;
    logic s2_err_d;
    logic step_err;

    gray_step_checker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_gray_step_checker (
        .clk_sys   (Clock_In),
        .rst       (Reset_In),
        .accept_in (Valid_In & adv1),
        .mode_in   (Mode_In),
        .data_in   (Data_In),
        .err_out   (step_err)
    );

    // The error flag rides alongside its word through both stages.
    always_comb begin
        s1_err_d = s1_err_q;
        s2_err_d = s2_err_q;
        if (adv1) begin
            s1_err_d = step_err;
        end
        if (adv2) begin
            s2_err_d = s1_err_q;
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            s1_err_q <= 1'b0;
            s2_err_q <= 1'b0;
        end else begin
            s1_err_q <= s1_err_d;
            s2_err_q <= s2_err_d;
        end
    end

    assign Gray_Step_Error_Out = s2_err_q & s2_valid_q;
`endif

endmodule : binary_gray_converter_pipelined

// File: tb/tb_binary_gray_converter_pipelined.sv
module tb_binary_gray_converter_pipelined;

    localparam int DW = 8;

    logic          Clock_In = 1'b0;
    logic          Reset_In;
    logic          Enable_In;
    logic          Mode_In;
    logic [DW-1:0] Data_In;
    logic          Valid_In;
    logic          Ready_Out;
    logic [DW-1:0] Data_Out;
    logic          Mode_Out;
    logic          Valid_Out;
    logic          Ready_In;
`ifdef GRAY_STEP_CHECK_EN
    logic          Gray_Step_Error_Out;
`endif

    binary_gray_converter_pipelined #(.DATA_WIDTH(DW)) dut (
        .Clock_In   (Clock_In),
        .Reset_In   (Reset_In),
        .Enable_In  (Enable_In),
        .Mode_In    (Mode_In),
        .Data_In    (Data_In),
        .Valid_In   (Valid_In),
        .Ready_Out  (Ready_Out),
        .Data_Out   (Data_Out),
        .Mode_Out   (Mode_Out),
        .Valid_Out  (Valid_Out),
        .Ready_In   (Ready_In)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .Gray_Step_Error_Out (Gray_Step_Error_Out)
`endif
    );

    always #5 Clock_In = ~Clock_In;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversions written from the arithmetic definitions.
    function automatic logic [DW-1:0] ref_b2g(input logic [DW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [DW-1:0] ref_g2b(input logic [DW-1:0] g);
        logic [DW-1:0] r;
        r = '0;
        for (int s = 0; s < DW; s++) r = r ^ (g >> s);
        return r;
    endfunction

    typedef struct packed {
        logic [DW-1:0] data;
        logic          mode;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            xfer_cnt = 0;
    int            err_seen = 0;
    logic [DW-1:0] last_err_data = '0;
    logic [DW-1:0] prev_m = '0;
    logic          prev_valid_m = 1'b0;
    logic          hold_pend = 1'b0;
    exp_t          held;

    // Scoreboard: decisions taken mid-cycle describe what the next edge does.
    always @(negedge Clock_In) begin
        exp_t e;
        logic xfer;
        if (!Reset_In) begin
            xfer = Valid_Out & Ready_In & Enable_In;
            if (hold_pend) begin
                chk("hold_valid", Valid_Out, 1);
                chk("hold_data", Data_Out, held.data);
                chk("hold_mode", Mode_Out, held.mode);
            end
            hold_pend = Valid_Out & !xfer;
            held.data = Data_Out;
            held.mode = Mode_Out;
            held.err  = 1'b0;
            if (xfer) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", Data_Out, e.data);
                    chk("sb_mode", Mode_Out, e.mode);
`ifdef GRAY_STEP_CHECK_EN
                    chk("sb_err", Gray_Step_Error_Out, e.err);
                    if (Gray_Step_Error_Out) begin
                        err_seen++;
                        last_err_data = Data_Out;
                    end
`endif
                end
            end
            if (Valid_In & Ready_Out) begin
                e.mode = Mode_In;
                e.data = Mode_In ? ref_g2b(Data_In) : ref_b2g(Data_In);
                e.err  = 1'b0;
                if (Mode_In) begin
                    e.err        = prev_valid_m && ($countones(Data_In ^ prev_m) > 1);
                    prev_m       = Data_In;
                    prev_valid_m = 1'b1;
                end else begin
                    prev_valid_m = 1'b0;
                end
                exp_q.push_back(e);
            end
        end
    end

    always @(posedge Reset_In) begin
        exp_q.delete();
        hold_pend    = 1'b0;
        prev_valid_m = 1'b0;
    end

    // Offer one word until accepted; returns 1 time unit after the accepting edge.
    task automatic push_word(input logic m, input logic [DW-1:0] d);
        int   cyc;
        logic acc;
        Mode_In  = m;
        Data_In  = d;
        Valid_In = 1'b1;
        cyc = 0;
        do begin
            @(negedge Clock_In);
            acc = Ready_Out;
            @(posedge Clock_In);
            #1;
            cyc++;
        end while (!acc && cyc < 50);
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    typedef struct {
        logic          mode;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
    } vec_t;

    // Single word into an empty pipeline: checks latency and one-cycle valid.
    task automatic send_one(input vec_t v, input int idx);
        push_word(v.mode, v.din);
        Valid_In = 1'b0;
        chk($sformatf("v%0d_not_yet", idx), Valid_Out, 0);
        @(posedge Clock_In); #1;
        chk($sformatf("v%0d_valid", idx), Valid_Out, 1);
        chk($sformatf("v%0d_data", idx), Data_Out, v.dout);
        chk($sformatf("v%0d_mode", idx), Mode_Out, v.mode);
        @(posedge Clock_In); #1;
        chk($sformatf("v%0d_one_cycle", idx), Valid_Out, 0);
    endtask

    task automatic pulse_reset();
        #2 Reset_In = 1'b1;
        #1;
        chk("rst_valid", Valid_Out, 0);
        chk("rst_data", Data_Out, 0);
        chk("rst_mode", Mode_Out, 0);
        @(negedge Clock_In); #2;
        Reset_In = 1'b0;
        @(posedge Clock_In); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   x0;
        logic [DW-1:0] last_d;
        logic [DW-1:0] f_data;
        logic          f_mode;
        logic          f_valid;

        vecs[0] = '{1'b0, 8'hB5, 8'hEF};
        vecs[1] = '{1'b1, 8'hEF, 8'hB5};
        vecs[2] = '{1'b1, 8'h80, 8'hFF};
        vecs[3] = '{1'b0, 8'h01, 8'h01};
        vecs[4] = '{1'b1, 8'h03, 8'h02};
        vecs[5] = '{1'b0, 8'hFF, 8'h80};

        Reset_In  = 1'b1;
        Enable_In = 1'b1;
        Mode_In   = 1'b0;
        Data_In   = '0;
        Valid_In  = 1'b0;
        Ready_In  = 1'b1;
        #12;
        chk("reset_valid", Valid_Out, 0);
        chk("reset_data", Data_Out, 0);
        chk("reset_mode", Mode_Out, 0);
        chk("reset_ready", Ready_Out, 1);
`ifdef GRAY_STEP_CHECK_EN
        chk("reset_err", Gray_Step_Error_Out, 0);
`endif
        #6 Reset_In = 1'b0;
        @(posedge Clock_In); #1;

        for (int i = 0; i < 6; i++) send_one(vecs[i], i);

        // Back-to-back interleaved modes.
        push_word(1'b0, 8'h01);
        chk("il_empty", Valid_Out, 0);
        push_word(1'b1, 8'h03);
        chk("il_out0", Data_Out, 8'h01);
        push_word(1'b0, 8'hFF);
        Valid_In = 1'b0;
        chk("il_out1", Data_Out, 8'h02);
        chk("il_mode1", Mode_Out, 1);
        @(posedge Clock_In); #1;
        chk("il_out2", Data_Out, 8'h80);
        chk("il_valid2", Valid_Out, 1);
        repeat (3) @(posedge Clock_In);
        #1;

        // Downstream backpressure for 3 cycles after the first output.
        x0 = xfer_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) push_word(1'b0, DW'(i));
                Valid_In = 1'b0;
            end
            begin
                logic saw_drop;
                int   c;
                c = 0;
                while (!Valid_Out && c < 20) begin
                    @(posedge Clock_In); #1;
                    c++;
                end
                chk("bp_first_out", Valid_Out, 1);
                Ready_In = 1'b0;
                saw_drop = 1'b0;
                repeat (3) begin
                    @(negedge Clock_In);
                    if (!Ready_Out) saw_drop = 1'b1;
                    chk("bp_hold_data", Data_Out, 8'h00);
                    chk("bp_hold_valid", Valid_Out, 1);
                    @(posedge Clock_In); #1;
                end
                chk("bp_ready_drop", saw_drop, 1);
                Ready_In = 1'b1;
            end
        join
        repeat (5) @(posedge Clock_In);
        #1;
        chk("bp_count", xfer_cnt - x0, 6);
        chk("bp_drained", exp_q.size(), 0);

        // Enable low for 4 cycles mid-stream.
        x0 = xfer_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) push_word(1'b1, DW'(8'h10 + i));
                Valid_In = 1'b0;
            end
            begin
                repeat (3) @(posedge Clock_In);
                #1;
                Enable_In = 1'b0;
                f_data  = Data_Out;
                f_mode  = Mode_Out;
                f_valid = Valid_Out;
                repeat (4) begin
                    @(negedge Clock_In);
                    chk("en_ready", Ready_Out, 0);
                    chk("en_data", Data_Out, f_data);
                    chk("en_mode", Mode_Out, f_mode);
                    chk("en_valid", Valid_Out, f_valid);
                    @(posedge Clock_In); #1;
                end
                Enable_In = 1'b1;
            end
        join
        repeat (5) @(posedge Clock_In);
        #1;
        chk("en_count", xfer_cnt - x0, 6);
        chk("en_drained", exp_q.size(), 0);

        // Reset with two words in flight.
        push_word(1'b0, 8'h21);
        push_word(1'b1, 8'h33);
        Valid_In = 1'b0;
        x0 = xfer_cnt;
        pulse_reset();
        repeat (4) @(posedge Clock_In);
        #1;
        chk("rst_flushed", xfer_cnt - x0, 0);
        send_one('{1'b0, 8'h3C, 8'h22}, 10);

`ifdef GRAY_STEP_CHECK_EN
        pulse_reset();
        x0 = err_seen;
        push_word(1'b1, 8'h00);
        push_word(1'b1, 8'h01);
        push_word(1'b1, 8'h01);
        push_word(1'b1, 8'h03);
        push_word(1'b1, 8'h06);
        push_word(1'b0, 8'h5A);
        push_word(1'b1, 8'h0F);
        Valid_In = 1'b0;
        repeat (4) @(posedge Clock_In);
        #1;
        chk("step_err_count", err_seen - x0, 1);
        chk("step_err_word", last_err_data, 8'h04);
`endif

        // Random traffic against the scoreboard.
        last_d = '0;
        for (int n = 0; n < 3000; n++) begin
            Valid_In  = ($urandom % 3) != 0;
            Mode_In   = $urandom % 2;
            if ($urandom % 2) last_d = last_d ^ DW'(1 << ($urandom % DW));
            else              last_d = DW'($urandom);
            Data_In   = last_d;
            Ready_In  = ($urandom % 4) != 0;
            Enable_In = ($urandom % 8) != 0;
            @(posedge Clock_In); #1;
        end
        Valid_In  = 1'b0;
        Ready_In  = 1'b1;
        Enable_In = 1'b1;
        repeat (6) @(posedge Clock_In);
        #1;
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_valid_idle", Valid_Out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_binary_gray_converter_pipelined

// File: doc/binary_gray_converter_pipelined.md
Name: binary_gray_converter_pipelined

Overview:
- Parametrised, bidirectional Binary<->Gray converter. Mode is selected per data word.
- Two-stage registered pipeline with valid/ready handshake on both sides.
- Global enable stalls the whole pipeline.
- Sits on streaming datapaths such as counter/pointer crossings and encoder front-ends. It is the clocked, width-generic successor to the fixed 8-bit combinational converter.

Parameters:
- DATA_WIDTH, 8, word width in bits; legal range >= 2.

Ports:
- Clock_In  input  1  clock; all state updates on rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  pipeline enable; low = full stall.
- Mode_In  input  1  0 = binary->Gray, 1 = Gray->binary; sampled with Data_In.
- Data_In  input  DATA_WIDTH  input word.
- Valid_In  input  1  Data_In/Mode_In valid.
- Ready_Out  output  1  block can accept this cycle.
- Data_Out  output  DATA_WIDTH  converted word.
- Mode_Out  output  1  mode tag travelling with Data_Out.
- Valid_Out  output  1  Data_Out valid.
- Ready_In  input  1  downstream can accept.
- Gray_Step_Error_Out  output  1  only present with GRAY_STEP_CHECK_EN.

Behaviour:
- Reset (async assert, sync release): S1/S2 valid = 0, data = 0, mode = 0. Outputs go to Data_Out = 0, Mode_Out = 0, Valid_Out = 0, error = 0. Ready_Out then follows the handshake equations.
- Stage registers:
  - S1 holds the captured input, mode and valid.
  - S2 holds the converted result, mode and valid.
- Advance conditions:
  - adv2 = Enable_In & (!S2_valid | Ready_In)
  - adv1 = Enable_In & (!S1_valid | adv2)
  - Ready_Out = adv1. This is a combinational path from Ready_In, which is allowed.
- Accept = Valid_In & Ready_Out. On adv1, S1 loads {Data_In, Mode_In, Valid_In}.
- On adv2, S2 loads {conv(S1), S1_mode, S1_valid}. Bubbles collapse.
- Latency: a word accepted at edge k appears on Data_Out with Valid_Out = 1 after edge k+1. Throughput is 1 word/cycle when Ready_In is held high.
- Output hold: Valid_Out/Data_Out/Mode_Out are held stable while Valid_Out & !Ready_In; no word is lost or duplicated.
- Conversion between S1 and S2:
  - binary->Gray: G = B ^ (B >> 1).
  - Gray->binary: B[W-1] = G[W-1]; B[i] = B[i+1] ^ G[i] for i = W-2..0.
- Enable_In low: all registers hold, Ready_Out = 0, and Valid_Out keeps its current value. Downstream may see a held valid word; a transfer completes only on a cycle with Enable_In high.
- Mixed modes back-to-back are legal; each word converts per its own tag.
- Reset mid-stream flushes both stages immediately; in-flight words are discarded.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- With the macro defined, the block checks consecutive Gray->binary inputs:
  - It tracks the last accepted Gray->binary input word plus a prev_valid flag.
  - On accepting a Gray->binary word with prev_valid = 1, err = (popcount(word ^ prev) > 1). Distance 0 is legal.
  - err travels through S1/S2 with the word; Gray_Step_Error_Out = S2_err & Valid_Out.
  - Accepting a binary->Gray word clears prev_valid. Reset clears prev_valid and err.
- Without the macro: the port is absent, there is no tracking logic, and behaviour is otherwise identical.

Decomposition:
- Package gray_conv_pkg holds:
  - constants MODE_BIN2GRAY = 1'b0 and MODE_GRAY2BIN = 1'b1;
  - functions bin2gray(w) and gray2bin(w), both width-generic via DATA_WIDTH.
- One sub-module, gray_step_checker: holds prev register, prev_valid, popcount compare and err output. It is instantiated only under GRAY_STEP_CHECK_EN.

Test Plan:
- W=8, Ready_In=1, Enable_In=1, Mode 0, Data 8'hB5 -> after edge k+1: Data_Out=8'hEF, Mode_Out=0, Valid_Out=1 for exactly one cycle.
- Mode 1, Data 8'hEF -> 8'hB5; Mode 1, 8'h80 -> 8'hFF. Interleaved modes 0/1/0 with 8'h01, 8'h03, 8'hFF -> 8'h01, 8'h02, 8'h80 in order.
- Stream 8'h00..8'h05, Ready_In low for 3 cycles after first output -> Ready_Out drops once both stages are full; Data_Out is held; all 6 results arrive in order, no loss or duplication.
- Enable_In low 4 cycles mid-stream -> Ready_Out=0, all outputs frozen; resume continues from the same word.
- Reset_In pulse asynchronously mid-stream with 2 words in flight -> Valid_Out=0 immediately; those words never appear; the next accepted word has 2-cycle latency.
- GRAY_STEP_CHECK_EN defined, Mode 1 stream 8'h00, 8'h01, 8'h01, 8'h03, 8'h06 -> Gray_Step_Error_Out=1 only with the 8'h06 result (8'h04); a Mode 0 word then 8'h0F -> no error.
